csr_regfile: RTL and testbench

- Consumer end of the writeback exception report: takes the WB stage's exception request, ecode and esubcode, and commits them into the LoongArch control/status registers.
- Also serves CSR read/write instructions, owns the constant timer, and produces the interrupt request sampled back at WB.
- Supplies the exception-entry and ERTN-return PCs to the fetch redirect.

---
 rtl/csr_regfile_if.sv | 34 +++
 rtl/csr_regfile.sv | 216 +++++++++++++++++++++
 tb/tb_csr_regfile.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_regfile_if.sv
// CSR access, writeback exception/ERTN commit, interrupt and redirect signals
// between the WB stage (master) and the CSR register file (slave).
interface csr_regfile_if;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [7:0]  wb_esubcode;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic        ertn_flush;
  logic [7:0]  hw_int_in;
  logic        ipi_int_in;
  logic        has_int;
  logic [31:0] ex_entry;
  logic [31:0] ertn_entry;

  modport master (
    output csr_num, csr_we, csr_wmask, csr_wvalue,
    output wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    output hw_int_in, ipi_int_in,
    input  csr_rvalue, has_int, ex_entry, ertn_entry
  );

  modport slave (
    input  csr_num, csr_we, csr_wmask, csr_wvalue,
    input  wb_ex, wb_ecode, wb_esubcode, wb_pc, wb_vaddr, ertn_flush,
    input  hw_int_in, ipi_int_in,
    output csr_rvalue, has_int, ex_entry, ertn_entry
  );
endinterface

// File: rtl/csr_regfile.sv
// LoongArch CSR register file: CSR read/write, exception/ERTN commit,
// constant timer and interrupt request generation.
module csr_regfile #(
  parameter int          TIMER_W = 32,
  parameter logic [31:0] TID_RST = 32'h0
) (
  input logic           clk,
  input logic           reset,
  csr_regfile_if.slave  bus
);

  localparam logic [13:0] CSR_CRMD   = 14'h000;
  localparam logic [13:0] CSR_PRMD   = 14'h001;
  localparam logic [13:0] CSR_ECFG   = 14'h004;
  localparam logic [13:0] CSR_ESTAT  = 14'h005;
  localparam logic [13:0] CSR_ERA    = 14'h006;
  localparam logic [13:0] CSR_BADV   = 14'h007;
  localparam logic [13:0] CSR_EENTRY = 14'h00C;
  localparam logic [13:0] CSR_SAVE0  = 14'h030;
  localparam logic [13:0] CSR_SAVE1  = 14'h031;
  localparam logic [13:0] CSR_SAVE2  = 14'h032;
  localparam logic [13:0] CSR_SAVE3  = 14'h033;
  localparam logic [13:0] CSR_TID    = 14'h040;
  localparam logic [13:0] CSR_TCFG   = 14'h041;
  localparam logic [13:0] CSR_TVAL   = 14'h042;
  localparam logic [13:0] CSR_TICLR  = 14'h044;

  localparam logic [5:0]  ECODE_ADEF = 6'h08;
  localparam logic [5:0]  ECODE_ALE  = 6'h09;
  localparam logic [12:0] LIE_MASK   = 13'h1BFF;

  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] val,
                                         input logic [31:0] mask);
    return (old_v & ~mask) | (val & mask);
  endfunction

  function automatic logic [TIMER_W-1:0] reload(input logic [29:0] initval);
    return TIMER_W'({initval, 2'b00});
  endfunction

  logic [1:0]         crmd_plv_q, crmd_plv_d;
  logic               crmd_ie_q, crmd_ie_d;
  logic               crmd_da_q, crmd_da_d;
  logic [1:0]         prmd_pplv_q, prmd_pplv_d;
  logic               prmd_pie_q, prmd_pie_d;
  logic [12:0]        ecfg_lie_q, ecfg_lie_d;
  logic [12:0]        estat_is_q, estat_is_d;
  logic [5:0]         estat_ecode_q, estat_ecode_d;
  logic [8:0]         estat_esub_q, estat_esub_d;
  logic [31:0]        era_q, era_d;
  logic [31:0]        badv_q, badv_d;
  logic [25:0]        eentry_va_q, eentry_va_d;
  logic [31:0]        save_q [4];
  logic [31:0]        save_d [4];
  logic [31:0]        tid_q, tid_d;
  logic               tcfg_en_q, tcfg_en_d;
  logic               tcfg_per_q, tcfg_per_d;
  logic [29:0]        tcfg_init_q, tcfg_init_d;
  logic [TIMER_W-1:0] timer_cnt_q, timer_cnt_d;

  logic [31:0] rdata;
  logic [31:0] nv;
  logic        we_eff;
  logic        tcfg_wr;
  logic        ticlr;
  logic        timer_fire;

  always_comb begin
    rdata = 32'h0;
    unique case (bus.csr_num)
      CSR_CRMD:   rdata = {28'h0, crmd_da_q, crmd_ie_q, crmd_plv_q};
      CSR_PRMD:   rdata = {29'h0, prmd_pie_q, prmd_pplv_q};
      CSR_ECFG:   rdata = {19'h0, ecfg_lie_q};
      CSR_ESTAT:  rdata = {1'b0, estat_esub_q, estat_ecode_q, 3'b000, estat_is_q};
      CSR_ERA:    rdata = era_q;
      CSR_BADV:   rdata = badv_q;
      CSR_EENTRY: rdata = {eentry_va_q, 6'h00};
      CSR_SAVE0:  rdata = save_q[0];
      CSR_SAVE1:  rdata = save_q[1];
      CSR_SAVE2:  rdata = save_q[2];
      CSR_SAVE3:  rdata = save_q[3];
      CSR_TID:    rdata = tid_q;
      CSR_TCFG:   rdata = {tcfg_init_q, tcfg_per_q, tcfg_en_q};
      CSR_TVAL:   rdata = 32'(timer_cnt_q);
      default:    rdata = 32'h0;
    endcase
  end

  assign bus.csr_rvalue = rdata;
  assign bus.has_int    = crmd_ie_q & (|(estat_is_q & ecfg_lie_q));
  assign bus.ex_entry   = {eentry_va_q, 6'h00};
  assign bus.ertn_entry = era_q;

  // Merging against the read mux works because reads and writes share csr_num.
  assign we_eff  = bus.csr_we & ~bus.wb_ex & ~bus.ertn_flush;
  assign nv      = wmerge(rdata, bus.csr_wvalue, bus.csr_wmask);
  assign tcfg_wr = we_eff && (bus.csr_num == CSR_TCFG);
  assign ticlr   = we_eff && (bus.csr_num == CSR_TICLR) && nv[0];

  always_comb begin
    crmd_plv_d    = crmd_plv_q;
    crmd_ie_d     = crmd_ie_q;
    crmd_da_d     = crmd_da_q;
    prmd_pplv_d   = prmd_pplv_q;
    prmd_pie_d    = prmd_pie_q;
    ecfg_lie_d    = ecfg_lie_q;
    estat_is_d    = estat_is_q;
    estat_ecode_d = estat_ecode_q;
    estat_esub_d  = estat_esub_q;
    era_d         = era_q;
    badv_d        = badv_q;
    eentry_va_d   = eentry_va_q;
    save_d        = save_q;
    tid_d         = tid_q;
    tcfg_en_d     = tcfg_en_q;
    tcfg_per_d    = tcfg_per_q;
    tcfg_init_d   = tcfg_init_q;
    timer_cnt_d   = timer_cnt_q;
    timer_fire    = 1'b0;

    estat_is_d[9:2] = bus.hw_int_in;
    estat_is_d[10]  = 1'b0;
    estat_is_d[12]  = bus.ipi_int_in;

    if (bus.wb_ex) begin
      prmd_pplv_d   = crmd_plv_q;
      prmd_pie_d    = crmd_ie_q;
      crmd_plv_d    = 2'b00;
      crmd_ie_d     = 1'b0;
      estat_ecode_d = bus.wb_ecode;
      estat_esub_d  = {1'b0, bus.wb_esubcode};
      era_d         = bus.wb_pc;
      if (bus.wb_ecode == ECODE_ADEF)     badv_d = bus.wb_pc;
      else if (bus.wb_ecode == ECODE_ALE) badv_d = bus.wb_vaddr;
    end else if (bus.ertn_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end else if (we_eff) begin
      unique case (bus.csr_num)
        CSR_CRMD:   begin crmd_plv_d = nv[1:0]; crmd_ie_d = nv[2]; crmd_da_d = nv[3]; end
        CSR_PRMD:   begin prmd_pplv_d = nv[1:0]; prmd_pie_d = nv[2]; end
        CSR_ECFG:   ecfg_lie_d = nv[12:0] & LIE_MASK;
        CSR_ESTAT:  estat_is_d[1:0] = nv[1:0];
        CSR_ERA:    era_d = nv;
        CSR_BADV:   badv_d = nv;
        CSR_EENTRY: eentry_va_d = nv[31:6];
        CSR_SAVE0:  save_d[0] = nv;
        CSR_SAVE1:  save_d[1] = nv;
        CSR_SAVE2:  save_d[2] = nv;
        CSR_SAVE3:  save_d[3] = nv;
        CSR_TID:    tid_d = nv;
        CSR_TCFG:   begin tcfg_en_d = nv[0]; tcfg_per_d = nv[1]; tcfg_init_d = nv[31:2]; end
        default:    ;
      endcase
    end

    // An all-ones count marks a one-shot timer that has already fired.
    if (tcfg_wr) begin
      if (tcfg_en_d) timer_cnt_d = reload(tcfg_init_d);
    end else if (tcfg_en_q) begin
      if (timer_cnt_q == '0) begin
        timer_fire  = 1'b1;
        timer_cnt_d = tcfg_per_q ? reload(tcfg_init_q) : '1;
      end else if (timer_cnt_q != '1) begin
        timer_cnt_d = timer_cnt_q - 1'b1;
      end
    end

    if (ticlr)      estat_is_d[11] = 1'b0;
    if (timer_fire) estat_is_d[11] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crmd_plv_q    <= 2'b00;
      crmd_ie_q     <= 1'b0;
      crmd_da_q     <= 1'b1;
      prmd_pplv_q   <= 2'b00;
      prmd_pie_q    <= 1'b0;
      ecfg_lie_q    <= '0;
      estat_is_q    <= '0;
      estat_ecode_q <= '0;
      estat_esub_q  <= '0;
      era_q         <= '0;
      badv_q        <= '0;
      eentry_va_q   <= '0;
      for (int i = 0; i < 4; i++) save_q[i] <= '0;
      tid_q         <= TID_RST;
      tcfg_en_q     <= 1'b0;
      tcfg_per_q    <= 1'b0;
      tcfg_init_q   <= '0;
      timer_cnt_q   <= '1;
    end else begin
      crmd_plv_q    <= crmd_plv_d;
      crmd_ie_q     <= crmd_ie_d;
      crmd_da_q     <= crmd_da_d;
      prmd_pplv_q   <= prmd_pplv_d;
      prmd_pie_q    <= prmd_pie_d;
      ecfg_lie_q    <= ecfg_lie_d;
      estat_is_q    <= estat_is_d;
      estat_ecode_q <= estat_ecode_d;
      estat_esub_q  <= estat_esub_d;
      era_q         <= era_d;
      badv_q        <= badv_d;
      eentry_va_q   <= eentry_va_d;
      for (int i = 0; i < 4; i++) save_q[i] <= save_d[i];
      tid_q         <= tid_d;
      tcfg_en_q     <= tcfg_en_d;
      tcfg_per_q    <= tcfg_per_d;
      tcfg_init_q   <= tcfg_init_d;
      timer_cnt_q   <= timer_cnt_d;
    end
  end

endmodule

// File: tb/tb_csr_regfile.sv
// Directed bench for csr_regfile: expected values are queued with each
// stimulus step and popped when the corresponding DUT output is sampled.
module tb_csr_regfile;
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  csr_regfile_if ifc ();

  csr_regfile #(.TIMER_W(32), .TID_RST(32'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  localparam logic [13:0] A_CRMD = 14'h000, A_PRMD = 14'h001, A_ECFG = 14'h004,
                          A_ESTAT = 14'h005, A_ERA = 14'h006, A_BADV = 14'h007,
                          A_EENTRY = 14'h00C, A_SAVE2 = 14'h032, A_TID = 14'h040,
                          A_TCFG = 14'h041, A_TVAL = 14'h042, A_TICLR = 14'h044;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;

  sb_t sbq[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic cmp(input logic [31:0] obs);
    sb_t e;
    e = sbq.pop_front();
    n_chk++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [13:0] addr, input logic [31:0] val, input logic [31:0] mask);
    ifc.csr_num    = addr;
    ifc.csr_wvalue = val;
    ifc.csr_wmask  = mask;
    ifc.csr_we     = 1'b1;
    tick();
    ifc.csr_we     = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [13:0] addr, input logic [31:0] exp,
                    input logic [31:0] mask = ALL);
    ifc.csr_num = addr;
    sbq.push_back('{tag, exp});
    #1;
    cmp(ifc.csr_rvalue & mask);
  endtask

  // sel: 0 = has_int, 1 = ex_entry, 2 = ertn_entry
  task automatic sig(input string tag, input int sel, input logic [31:0] exp);
    sbq.push_back('{tag, exp});
    #1;
    case (sel)
      0:       cmp({31'h0, ifc.has_int});
      1:       cmp(ifc.ex_entry);
      default: cmp(ifc.ertn_entry);
    endcase
  endtask

  initial begin
    ifc.csr_num     = '0;
    ifc.csr_we      = 1'b0;
    ifc.csr_wmask   = '0;
    ifc.csr_wvalue  = '0;
    ifc.wb_ex       = 1'b0;
    ifc.wb_ecode    = '0;
    ifc.wb_esubcode = '0;
    ifc.wb_pc       = '0;
    ifc.wb_vaddr    = '0;
    ifc.ertn_flush  = 1'b0;
    ifc.hw_int_in   = '0;
    ifc.ipi_int_in  = 1'b0;

    // Reset values before any clock edge
    #1 reset = 1'b1;
    rd("rst_crmd", A_CRMD, 32'h8);
    rd("rst_estat", A_ESTAT, 32'h0);
    rd("rst_tval", A_TVAL, ALL);
    rd("rst_tid", A_TID, 32'h0);
    sig("rst_has_int", 0, 0);
    tick();
    reset = 1'b0;

    // Plain writes, unimplemented address, masked ECFG write
    wr(A_CRMD, 32'h7, ALL);
    wr(A_EENTRY, 32'h1C00_8000, ALL);
    rd("crmd_wr", A_CRMD, 32'h7);
    rd("eentry_wr", A_EENTRY, 32'h1C00_8000);
    sig("ex_entry_pre", 1, 32'h1C00_8000);
    rd("unimpl_rd", 14'h002, 32'h0);
    wr(A_SAVE2, 32'hDEAD_BEEF, ALL);
    rd("save2", A_SAVE2, 32'hDEAD_BEEF);
    wr(A_ECFG, 32'h0, ALL);
    wr(A_ECFG, ALL, 32'h0000_0F0F);
    rd("ecfg_masked", A_ECFG, 32'h0000_0B0F);

    // Exception commit: ALE
    ifc.wb_ex = 1'b1; ifc.wb_ecode = 6'h09; ifc.wb_esubcode = 8'h00;
    ifc.wb_pc = 32'h1C00_0104; ifc.wb_vaddr = 32'h0000_0003;
    tick();
    ifc.wb_ex = 1'b0;
    rd("ex_crmd", A_CRMD, 32'h0);
    rd("ex_prmd", A_PRMD, 32'h7);
    rd("ex_era", A_ERA, 32'h1C00_0104);
    rd("ex_badv", A_BADV, 32'h3);
    rd("ex_ecode", A_ESTAT, 32'h0009_0000, 32'h003F_0000);
    sig("ex_entry", 1, 32'h1C00_8000);

    // ERTN restores PLV/IE
    ifc.ertn_flush = 1'b1;
    tick();
    ifc.ertn_flush = 1'b0;
    rd("ertn_crmd", A_CRMD, 32'h7);
    sig("ertn_entry", 2, 32'h1C00_0104);

    // wb_ex + ertn_flush + csr_we together: only the exception lands
    ifc.wb_ex = 1'b1; ifc.wb_ecode = 6'h08; ifc.wb_pc = 32'h1C00_0200;
    ifc.ertn_flush = 1'b1;
    ifc.csr_num = A_CRMD; ifc.csr_wvalue = 32'h8; ifc.csr_wmask = 32'h8; ifc.csr_we = 1'b1;
    tick();
    ifc.wb_ex = 1'b0; ifc.ertn_flush = 1'b0; ifc.csr_we = 1'b0;
    rd("conf_crmd", A_CRMD, 32'h0);
    rd("conf_prmd", A_PRMD, 32'h7);
    rd("conf_era", A_ERA, 32'h1C00_0200);
    rd("conf_badv_adef", A_BADV, 32'h1C00_0200);
    rd("conf_estat", A_ESTAT, 32'h0008_0000);

    // One-shot timer, InitVal = 2
    wr(A_CRMD, 32'h4, ALL);
    sig("pre_timer_int", 0, 0);
    wr(A_TCFG, 32'h9, ALL);
    for (int i = 8; i >= 0; i--) begin
      rd($sformatf("os_tval_%0d", i), A_TVAL, 32'(i));
      if (i > 0) tick();
    end
    rd("os_is11_pre", A_ESTAT, 32'h0, 32'h800);
    tick();
    rd("os_is11_set", A_ESTAT, 32'h800, 32'h800);
    rd("os_tval_stop", A_TVAL, ALL);
    sig("os_has_int", 0, 1);
    tick();
    rd("os_tval_hold", A_TVAL, ALL);
    wr(A_TICLR, 32'h1, ALL);
    rd("ticlr_clr", A_ESTAT, 32'h0, 32'h800);
    rd("ticlr_rd0", A_TICLR, 32'h0);
    sig("ticlr_int", 0, 0);

    // Periodic timer, TICLR on the fire cycle
    wr(A_TCFG, 32'hB, ALL);
    rd("per_tval_8", A_TVAL, 32'h8);
    for (int i = 0; i < 8; i++) tick();
    rd("per_tval_0", A_TVAL, 32'h0);
    wr(A_TICLR, 32'h1, ALL);
    rd("per_set_wins", A_ESTAT, 32'h800, 32'h800);
    rd("per_reload", A_TVAL, 32'h8);
    wr(A_TICLR, 32'h1, ALL);
    rd("per_clr", A_ESTAT, 32'h0, 32'h800);
    wr(A_TCFG, 32'h0, ALL);
    rd("freeze_a", A_TVAL, 32'h7);
    tick();
    rd("freeze_b", A_TVAL, 32'h7);

    // External and IPI interrupts
    wr(A_ECFG, 32'h004, ALL);
    ifc.hw_int_in = 8'h01;
    sig("hw_int_unsampled", 0, 0);
    tick();
    sig("hw_int_on", 0, 1);
    wr(A_ECFG, 32'h0, ALL);
    sig("hw_int_masked", 0, 0);
    ifc.ipi_int_in = 1'b1;
    wr(A_ECFG, 32'h1000, ALL);
    rd("ipi_is12", A_ESTAT, 32'h1000, 32'h1000);
    sig("ipi_int", 0, 1);
    wr(A_ESTAT, ALL, ALL);
    rd("estat_sw_wr", A_ESTAT, 32'h0008_1007);

    // Asynchronous reset while the timer is counting
    wr(A_TCFG, 32'h9, ALL);
    tick();
    tick();
    rd("mid_tval", A_TVAL, 32'h6);
    #2 reset = 1'b1;
    sig("mid_rst_int", 0, 0);
    rd("mid_rst_crmd", A_CRMD, 32'h8);
    rd("mid_rst_estat", A_ESTAT, 32'h0);
    rd("mid_rst_tval", A_TVAL, ALL);
    tick();
    rd("mid_rst_tval_hold", A_TVAL, ALL);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
